// File: rtl/trap_ctrl_if.sv
// Signal bundle between the core and the machine-mode trap controller.
// trap_ctrl takes the slave side; the core (or a bench) takes the master side.
interface trap_ctrl_if;
    logic        int_req;
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] pc;
    logic        mret;
    logic        halt_ack;
    logic        core_csr_w_en;
    logic [11:0] core_csr_addr;
    logic [31:0] core_csr_w_data;
    logic        csr_w_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_w_data;
    logic        core_csr_stall;
    logic        halt_req;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        in_trap;

    modport slave (
        input  int_req, mstatus, mie, mtvec, mepc, pc, mret, halt_ack,
        input  core_csr_w_en, core_csr_addr, core_csr_w_data,
        output csr_w_en, csr_addr, csr_w_data, core_csr_stall,
        output halt_req, pc_load, pc_load_value, in_trap
    );

    modport master (
        output int_req, mstatus, mie, mtvec, mepc, pc, mret, halt_ack,
        output core_csr_w_en, core_csr_addr, core_csr_w_data,
        input  csr_w_en, csr_addr, csr_w_data, core_csr_stall,
        input  halt_req, pc_load, pc_load_value, in_trap
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine external-interrupt entry and mret return sequencer: halts the core,
// performs the trap CSR updates over the shared CSR write port and redirects the PC.
module trap_ctrl (
    input  logic       clock,
    input  logic       reset_n,
    trap_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, T_HALT, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, T_VEC,
        HANDLER, R_HALT, R_MSTAT, R_VEC
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] saved_pc_q, saved_pc_d;
    logic        mret_pend_q, mret_pend_d;
    logic        take;
    logic        pass;
    logic        own_wr;
    logic [11:0] own_addr;
    logic [31:0] own_data;
    logic [31:0] vec_base;
    logic        unused_ok;

    assign take      = bus.int_req & bus.mstatus[3] & bus.mie[11];
    assign vec_base  = {bus.mtvec[31:2], 2'b00};
    assign unused_ok = ^{bus.mie[31:12], bus.mie[10:0], bus.mepc[1:0]};

    function automatic logic [31:0] entry_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r        = ms;
        r[3]     = 1'b0;
        r[7]     = ms[3];
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] return_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r        = ms;
        r[3]     = ms[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            saved_pc_q  <= '0;
            mret_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            saved_pc_q  <= saved_pc_d;
            mret_pend_q <= mret_pend_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        saved_pc_d        = saved_pc_q;
        mret_pend_d       = mret_pend_q | bus.mret;
        pass              = 1'b0;
        own_wr            = 1'b0;
        own_addr          = '0;
        own_data          = '0;
        bus.halt_req      = 1'b0;
        bus.in_trap       = 1'b0;
        bus.pc_load       = 1'b0;
        bus.pc_load_value = '0;

        case (state_q)
            IDLE: begin
                pass = 1'b1;
                if (take)             state_d = T_HALT;
                else if (mret_pend_q) state_d = R_HALT;
            end
            T_HALT: begin
                pass         = 1'b1;
                bus.halt_req = 1'b1;
                if (bus.halt_ack) begin
                    saved_pc_d = bus.pc;
                    state_d    = W_MEPC;
                end
            end
            W_MEPC: begin
                bus.halt_req = 1'b1;
                bus.in_trap  = 1'b1;
                own_wr       = 1'b1;
                own_addr     = 12'h341;
                own_data     = saved_pc_q;
                state_d      = W_MCAUSE;
            end
            W_MCAUSE: begin
                bus.halt_req = 1'b1;
                bus.in_trap  = 1'b1;
                own_wr       = 1'b1;
                own_addr     = 12'h342;
                own_data     = 32'h8000_000B;
                state_d      = W_MTVAL;
            end
            W_MTVAL: begin
                bus.halt_req = 1'b1;
                bus.in_trap  = 1'b1;
                own_wr       = 1'b1;
                own_addr     = 12'h343;
                state_d      = W_MSTAT;
            end
            W_MSTAT: begin
                bus.halt_req = 1'b1;
                bus.in_trap  = 1'b1;
                own_wr       = 1'b1;
                own_addr     = 12'h300;
                own_data     = entry_mstatus(bus.mstatus);
                state_d      = T_VEC;
            end
            T_VEC: begin
                bus.halt_req      = 1'b1;
                bus.in_trap       = 1'b1;
                bus.pc_load       = reset_n;
                // Non-zero mode bits select vectored dispatch: base + 4*cause(11)
                bus.pc_load_value = (bus.mtvec[1:0] == 2'b00) ? vec_base
                                                              : vec_base + 32'h2C;
                state_d           = HANDLER;
            end
            HANDLER: begin
                pass        = 1'b1;
                bus.in_trap = 1'b1;
                if (mret_pend_q) state_d = R_HALT;
            end
            R_HALT: begin
                pass         = 1'b1;
                bus.halt_req = 1'b1;
                bus.in_trap  = 1'b1;
                if (bus.halt_ack) state_d = R_MSTAT;
            end
            R_MSTAT: begin
                bus.halt_req = 1'b1;
                bus.in_trap  = 1'b1;
                own_wr       = 1'b1;
                own_addr     = 12'h300;
                own_data     = return_mstatus(bus.mstatus);
                state_d      = R_VEC;
            end
            R_VEC: begin
                bus.halt_req      = 1'b1;
                bus.in_trap       = 1'b1;
                bus.pc_load       = reset_n;
                bus.pc_load_value = {bus.mepc[31:2], 2'b00};
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Entering R_HALT consumes the pending flag, including a pulse in this same cycle
        if (state_d == R_HALT && state_q != R_HALT) mret_pend_d = 1'b0;

        // A controller write cut short by reset must never reach the CSR file
        bus.csr_w_en       = pass ? bus.core_csr_w_en : (own_wr & reset_n);
        bus.csr_addr       = pass ? bus.core_csr_addr : own_addr;
        bus.csr_w_data     = pass ? bus.core_csr_w_data : own_data;
        bus.core_csr_stall = own_wr & bus.core_csr_w_en;
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized bench for trap_ctrl: expected port values come from a transaction-level
// model of the trap entry / return sequences.
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trap_ctrl_if bus();

    trap_ctrl dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [80:0] obs;
    logic [80:0] expv;

    assign obs = {bus.halt_req, bus.in_trap, bus.pc_load, bus.pc_load_value,
                  bus.csr_w_en, bus.csr_addr, bus.csr_w_data, bus.core_csr_stall};

    function automatic logic [80:0] ev(logic h, logic t, logic l, logic [31:0] v,
                                       logic en, logic [11:0] a, logic [31:0] d, logic s);
        return {h, t, l, v, en, a, d, s};
    endfunction

    // Passthrough cycle: the core's write appears unchanged and is never stalled
    function automatic logic [80:0] pass_ev(logic h, logic t);
        return ev(h, t, 1'b0, 32'h0, bus.core_csr_w_en, bus.core_csr_addr,
                  bus.core_csr_w_data, 1'b0);
    endfunction

    function automatic logic [31:0] ms_entry(logic [31:0] ms);
        return (ms & ~32'h88) | (((ms >> 3) & 32'h1) << 7) | 32'h1800;
    endfunction

    function automatic logic [31:0] ms_return(logic [31:0] ms);
        return (ms & ~32'h88) | (((ms >> 7) & 32'h1) << 3) | 32'h80 | 32'h1800;
    endfunction

    function automatic logic [31:0] vec_target(logic [31:0] tv);
        return (tv & ~32'h3) + (((tv & 32'h3) != 0) ? 32'h2C : 32'h0);
    endfunction

    task automatic rand_core();
        bus.core_csr_w_en   = 1'($urandom_range(0, 1));
        bus.core_csr_addr   = 12'($urandom);
        bus.core_csr_w_data = $urandom;
    endtask

    task automatic zero_core();
        bus.core_csr_w_en   = 1'b0;
        bus.core_csr_addr   = '0;
        bus.core_csr_w_data = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.int_req = 1'b0; bus.mstatus = '0; bus.mie = '0; bus.mtvec = '0;
        bus.mepc = '0; bus.pc = '0; bus.mret = 1'b0; bus.halt_ack = 1'b0;
        zero_core();
        next_cycle();
        next_cycle();
        @(negedge clk);
        expv = '0;
        n_checks++;
        if (obs !== expv) $display("FAIL reset_state: got %h want %h", obs, expv);
        else n_pass++;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        expv = '0;
        n_checks++;
        if (obs !== expv) $display("FAIL idle_after_reset: got %h want %h", obs, expv);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_entry(logic [31:0] ms, logic [31:0] ie, logic [31:0] pcv,
                              logic [31:0] tv, int ack_dly);
        logic [11:0] wa [4];
        logic [31:0] wd [4];
        wa[0] = 12'h341; wd[0] = pcv;
        wa[1] = 12'h342; wd[1] = 32'h8000_000B;
        wa[2] = 12'h343; wd[2] = 32'h0;
        wa[3] = 12'h300; wd[3] = ms_entry(ms);
        bus.int_req = 1'b1; bus.mstatus = ms; bus.mie = ie; bus.mtvec = tv;
        bus.pc = pcv; bus.halt_ack = 1'b0; bus.mret = 1'b0;
        rand_core();
        @(negedge clk);
        expv = pass_ev(1'b0, 1'b0);
        n_checks++;
        if (obs !== expv) $display("FAIL entry_idle: got %h want %h", obs, expv);
        else n_pass++;
        next_cycle();
        for (int k = 0; k < ack_dly; k++) begin
            rand_core();
            bus.pc = $urandom;
            @(negedge clk);
            expv = pass_ev(1'b1, 1'b0);
            n_checks++;
            if (obs !== expv) $display("FAIL entry_wait_ack: got %h want %h", obs, expv);
            else n_pass++;
            next_cycle();
        end
        bus.halt_ack = 1'b1;
        bus.pc = pcv;
        rand_core();
        @(negedge clk);
        expv = pass_ev(1'b1, 1'b0);
        n_checks++;
        if (obs !== expv) $display("FAIL entry_ack: got %h want %h", obs, expv);
        else n_pass++;
        next_cycle();
        bus.halt_ack = 1'b0;
        bus.int_req = 1'b0;
        bus.pc = $urandom;
        for (int i = 0; i < 4; i++) begin
            rand_core();
            @(negedge clk);
            expv = ev(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, wa[i], wd[i], bus.core_csr_w_en);
            n_checks++;
            if (obs !== expv) $display("FAIL entry_csr_write%0d: got %h want %h", i, obs, expv);
            else n_pass++;
            next_cycle();
        end
        rand_core();
        @(negedge clk);
        expv = ev(1'b1, 1'b1, 1'b1, vec_target(tv), 1'b0, 12'h0, 32'h0, 1'b0);
        n_checks++;
        if (obs !== expv) $display("FAIL entry_pc_load: got %h want %h", obs, expv);
        else n_pass++;
        next_cycle();
        bus.int_req = 1'b1;
        rand_core();
        @(negedge clk);
        expv = pass_ev(1'b0, 1'b1);
        n_checks++;
        if (obs !== expv) $display("FAIL handler: got %h want %h", obs, expv);
        else n_pass++;
        next_cycle();
        bus.int_req = 1'b0;
    endtask

    task automatic test_return(logic [31:0] ms, logic [31:0] epc, int ack_dly, logic from_idle);
        logic found;
        found = 1'b0;
        bus.mstatus = ms; bus.mepc = epc; bus.mret = 1'b1; bus.halt_ack = 1'b0;
        rand_core();
        @(negedge clk);
        expv = pass_ev(1'b0, !from_idle);
        n_checks++;
        if (obs !== expv) $display("FAIL ret_pulse: got %h want %h", obs, expv);
        else n_pass++;
        next_cycle();
        bus.mret = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            rand_core();
            @(negedge clk);
            if (bus.halt_req === 1'b1) begin
                found = 1'b1;
                expv = pass_ev(1'b1, 1'b1);
            end else begin
                expv = pass_ev(1'b0, !from_idle);
            end
            n_checks++;
            if (obs !== expv) $display("FAIL ret_pending: got %h want %h", obs, expv);
            else n_pass++;
            next_cycle();
        end
        n_checks++;
        if (found !== 1'b1) begin
            $display("FAIL ret_halt_timeout: got %b want 1", found);
            return;
        end
        n_pass++;
        for (int k = 0; k < ack_dly; k++) begin
            rand_core();
            @(negedge clk);
            expv = pass_ev(1'b1, 1'b1);
            n_checks++;
            if (obs !== expv) $display("FAIL ret_wait_ack: got %h want %h", obs, expv);
            else n_pass++;
            next_cycle();
        end
        bus.halt_ack = 1'b1;
        rand_core();
        @(negedge clk);
        expv = pass_ev(1'b1, 1'b1);
        n_checks++;
        if (obs !== expv) $display("FAIL ret_ack: got %h want %h", obs, expv);
        else n_pass++;
        next_cycle();
        bus.halt_ack = 1'b0;
        rand_core();
        @(negedge clk);
        expv = ev(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 12'h300, ms_return(ms), bus.core_csr_w_en);
        n_checks++;
        if (obs !== expv) $display("FAIL ret_mstatus: got %h want %h", obs, expv);
        else n_pass++;
        next_cycle();
        rand_core();
        @(negedge clk);
        expv = ev(1'b1, 1'b1, 1'b1, epc & ~32'h3, 1'b0, 12'h0, 32'h0, 1'b0);
        n_checks++;
        if (obs !== expv) $display("FAIL ret_pc_load: got %h want %h", obs, expv);
        else n_pass++;
        next_cycle();
        rand_core();
        @(negedge clk);
        expv = pass_ev(1'b0, 1'b0);
        n_checks++;
        if (obs !== expv) $display("FAIL ret_idle: got %h want %h", obs, expv);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_masking();
        for (int i = 0; i < 6; i++) begin
            bus.mstatus = $urandom;
            bus.mie = $urandom;
            if (i % 2 == 0) bus.mie[11] = 1'b0;
            else            bus.mstatus[3] = 1'b0;
            bus.int_req = 1'b1;
            for (int c = 0; c < 3; c++) begin
                rand_core();
                @(negedge clk);
                expv = pass_ev(1'b0, 1'b0);
                n_checks++;
                if (obs !== expv) $display("FAIL mask%0d: got %h want %h", i, obs, expv);
                else n_pass++;
                next_cycle();
            end
        end
        bus.int_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.int_req = 1'b1; bus.mstatus = 32'h8; bus.mie = 32'h800;
        bus.pc = 32'h200; bus.halt_ack = 1'b1; bus.mret = 1'b0;
        zero_core();
        next_cycle();
        bus.int_req = 1'b0;
        next_cycle();
        bus.halt_ack = 1'b0;
        rand_core();
        @(negedge clk);
        expv = ev(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 12'h341, 32'h200, bus.core_csr_w_en);
        n_checks++;
        if (obs !== expv) $display("FAIL mid_mepc: got %h want %h", obs, expv);
        else n_pass++;
        next_cycle();
        bus.core_csr_w_en = 1'b1;
        bus.core_csr_addr = 12'($urandom);
        bus.core_csr_w_data = $urandom;
        @(negedge clk);
        expv = ev(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 12'h342, 32'h8000_000B, 1'b1);
        n_checks++;
        if (obs !== expv) $display("FAIL arb_stall: got %h want %h", obs, expv);
        else n_pass++;
        next_cycle();
        rst_n = 1'b0;
        zero_core();
        @(negedge clk);
        n_checks++;
        if ({bus.csr_w_en, bus.pc_load} !== 2'b00)
            $display("FAIL mid_no_mtval_write: got %b want 00", {bus.csr_w_en, bus.pc_load});
        else n_pass++;
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            expv = '0;
            n_checks++;
            if (obs !== expv) $display("FAIL post_reset%0d: got %h want %h", c, obs, expv);
            else n_pass++;
            next_cycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ms, ie;
        test_reset();
        test_entry(32'h8, 32'h800, 32'h100, 32'h500, 3);
        test_return(32'h1880, 32'h100, 1, 1'b0);
        test_entry(32'h8, 32'h800, 32'h0000_4444, 32'h501, 0);
        test_return(32'h1880, 32'h0000_4446, 0, 1'b0);
        test_masking();
        for (int r = 0; r < 6; r++) begin
            ms = $urandom | 32'h8;
            ie = $urandom | 32'h800;
            test_entry(ms, ie, $urandom, $urandom, int'($urandom_range(0, 4)));
            test_return($urandom, $urandom, int'($urandom_range(0, 4)), 1'b0);
        end
        test_return($urandom, $urandom, 2, 1'b1);
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
